// File: rtl/alu_cmd_queue_if.sv
// Command and result handshake bundle for alu_cmd_queue.
// The master side produces commands and consumes results; the slave side
// is the queue itself.
interface alu_cmd_queue_if #(
  parameter int n = 8
);
  // Command channel
  logic         in_valid;
  logic         in_ready;
  logic [n-1:0] in_a;
  logic [n-1:0] in_b;
  logic [2:0]   in_sel;

  // Result channel
  logic         out_valid;
  logic         out_ready;
  logic [n:0]   out_q;
  logic         out_zero;
  logic         out_dz;

  modport master (
    output in_valid, in_a, in_b, in_sel, out_ready,
    input  in_ready, out_valid, out_q, out_zero, out_dz
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sel, out_ready,
    output in_ready, out_valid, out_q, out_zero, out_dz
  );
endinterface

// File: rtl/alu_cmd_queue.sv
// Command FIFO in front of a combinational ALU plus a registered,
// back-pressured result stage behind it. One command issues per cycle
// whenever the result register is free or being drained that same cycle.
module alu_cmd_queue #(
  parameter int n     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  alu_cmd_queue_if.slave           bus,
  output logic [n-1:0]             alu_a,
  output logic [n-1:0]             alu_b,
  output logic [2:0]               alu_sel,
  output logic                     alu_en,
  input  logic [n:0]               alu_q,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] SEL_DIV = 3'b011;

  typedef struct packed {
    logic [n-1:0] a;
    logic [n-1:0] b;
    logic [2:0]   sel;
  } cmd_t;

  cmd_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  cmd_t          head;
  logic          empty;
  logic          push;
  logic          issue;

  // No pass-through when full: in_ready depends on occupancy alone, so a
  // pop in the same cycle never opens a slot early.
  assign empty        = (count == '0);
  assign bus.in_ready = (count < CW'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  assign issue        = !empty && (!bus.out_valid || bus.out_ready);
  assign head         = mem[rd_ptr];
  assign alu_en       = issue;

  // Present the FIFO head to the ALU; park the operands at zero when empty.
  always_comb begin
    // NOTE: every output gets a default before the conditional so no latch is inferred.
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = '0;
    if (!empty) begin
      alu_a   = head.a;
      alu_b   = head.b;
      alu_sel = head.sel;
    end
  end

  // Command storage write port.
  // NOTE: the storage array has no reset; entries are only read once count
  // says they were written, so clearing them would buy nothing.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{a: bus.in_a, b: bus.in_b, sel: bus.in_sel};
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + PW'(1);
      if (issue) rd_ptr <= rd_ptr + PW'(1);
      case ({push, issue})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Result register: capture on issue, drop valid once drained with no refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_q     <= '0;
      bus.out_zero  <= 1'b0;
      bus.out_dz    <= 1'b0;
    end else if (issue) begin
      bus.out_valid <= 1'b1;
      bus.out_q     <= alu_q;
      bus.out_zero  <= (alu_q[n-1:0] == '0);
      bus.out_dz    <= (head.sel == SEL_DIV) && (head.b == '0);
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Directed and random checks for alu_cmd_queue with a behavioural ALU
// attached to the alu_* ports.
module tb_alu_cmd_queue;

  localparam int N     = 8;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [2:0]   alu_sel;
  logic         alu_en;
  logic [N:0]   alu_q;
  logic [2:0]   count;

  alu_cmd_queue_if #(.n(N)) bus ();

  alu_cmd_queue #(.n(N), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_sel (alu_sel),
    .alu_en  (alu_en),
    .alu_q   (alu_q),
    .count   (count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N:0] q;
    logic       zero;
    logic       dz;
  } res_t;

  int   checks   = 0;
  int   errors   = 0;
  int   pushed   = 0;
  int   received = 0;
  res_t exp_q[$];

  // Behavioural ALU: n+1-bit result, all-ones on divide-by-zero.
  function automatic logic [N:0] alu_f(input logic [N-1:0] a, input logic [N-1:0] b,
                                       input logic [2:0] s);
    logic [2*N-1:0] p;
    case (s)
      3'd0: return {1'b0, a} + {1'b0, b};
      3'd1: return {1'b0, a} - {1'b0, b};
      3'd2: begin p = a * b; return p[N:0]; end
      3'd3: return (b == '0) ? '1 : {1'b0, a / b};
      3'd4: return {1'b0, a & b};
      3'd5: return {1'b0, a | b};
      3'd6: return {1'b0, a ^ b};
      default: return {1'b0, ~(a | b)};
    endcase
  endfunction

  function automatic res_t mk_res(input logic [N-1:0] a, input logic [N-1:0] b,
                                  input logic [2:0] s);
    res_t r;
    r.q    = alu_f(a, b, s);
    r.zero = (r.q[N-1:0] == '0);
    r.dz   = (s == 3'd3) && (b == '0);
    return r;
  endfunction

  assign alu_q = alu_en ? alu_f(alu_a, alu_b, alu_sel) : '0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [2:0] s);
    bus.in_valid = v;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_sel   = s;
  endtask

  // One clock with scoreboard bookkeeping: score a result consumed at the
  // coming edge and record a command accepted at it.
  task automatic cycle();
    res_t e;
    #1;
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 16'(bus.out_valid), 16'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_q",    16'(bus.out_q),    16'(e.q));
        check("sb_zero", 16'(bus.out_zero), 16'(e.zero));
        check("sb_dz",   16'(bus.out_dz),   16'(e.dz));
        received++;
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      exp_q.push_back(mk_res(bus.in_a, bus.in_b, bus.in_sel));
      pushed++;
    end
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N:0] exp2 [5];
    exp2[0] = 9'h003; exp2[1] = 9'h002; exp2[2] = 9'h00C; exp2[3] = 9'h004; exp2[4] = 9'h0FF;

    drive(1'b0, '0, '0, '0);
    bus.out_ready = 1'b0;

    // Reset state
    #12;
    check("rst_out_valid", 16'(bus.out_valid), 16'd0);
    check("rst_count",     16'(count),         16'd0);
    check("rst_in_ready",  16'(bus.in_ready),  16'd1);
    check("rst_alu_en",    16'(alu_en),        16'd0);
    check("rst_out_q",     16'(bus.out_q),     16'd0);
    check("rst_alu_a",     16'(alu_a),         16'd0);
    rst_n = 1'b1;
    step();

    // 1. Single add 0x0F + 0x01
    bus.out_ready = 1'b1;
    drive(1'b1, 8'h0F, 8'h01, 3'd0);
    #1;
    check("s1_en_idle", 16'(alu_en), 16'd0);
    step();
    drive(1'b0, '0, '0, '0);
    #1;
    check("s1_count",   16'(count),   16'd1);
    check("s1_alu_en",  16'(alu_en),  16'd1);
    check("s1_alu_a",   16'(alu_a),   16'h0F);
    check("s1_alu_b",   16'(alu_b),   16'h01);
    step();
    check("s1_valid",   16'(bus.out_valid), 16'd1);
    check("s1_q",       16'(bus.out_q),     16'h010);
    check("s1_zero",    16'(bus.out_zero),  16'd0);
    check("s1_dz",      16'(bus.out_dz),    16'd0);
    check("s1_en_done", 16'(alu_en),        16'd0);
    step();
    check("s1_drained", 16'(bus.out_valid), 16'd0);

    // 2. Back-pressure: five pushes with out_ready low
    bus.out_ready = 1'b0;
    drive(1'b1, 8'h01, 8'h02, 3'd0); step();
    drive(1'b1, 8'h05, 8'h03, 3'd1); step();
    drive(1'b1, 8'h04, 8'h03, 3'd2); step();
    drive(1'b1, 8'h09, 8'h02, 3'd3); step();
    drive(1'b1, 8'hF0, 8'h0F, 3'd5); step();
    check("s2_full_count", 16'(count),        16'd4);
    check("s2_full_ready", 16'(bus.in_ready), 16'd0);
    check("s2_held_q",     16'(bus.out_q),    16'h003);
    drive(1'b1, 8'hAA, 8'h55, 3'd4); step();
    check("s2_no_push_full", 16'(count), 16'd4);
    drive(1'b0, '0, '0, '0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("s2_valid", 16'(bus.out_valid), 16'd1);
      check("s2_q",     16'(bus.out_q),     16'(exp2[i]));
      check("s2_count", 16'(count),         16'(4 - i));
      step();
    end
    check("s2_end_valid", 16'(bus.out_valid), 16'd0);
    check("s2_end_count", 16'(count),         16'd0);

    // 3. Divide-by-zero then an all-zero xor
    drive(1'b1, 8'h12, 8'h00, 3'd3); step();
    drive(1'b1, 8'h33, 8'h33, 3'd6); step();
    drive(1'b0, '0, '0, '0);
    check("s3_dz_valid", 16'(bus.out_valid), 16'd1);
    check("s3_dz_flag",  16'(bus.out_dz),    16'd1);
    check("s3_dz_q",     16'(bus.out_q),     16'h1FF);
    check("s3_dz_zero",  16'(bus.out_zero),  16'd0);
    step();
    check("s3_x_q",    16'(bus.out_q),    16'h000);
    check("s3_x_zero", 16'(bus.out_zero), 16'd1);
    check("s3_x_dz",   16'(bus.out_dz),   16'd0);
    step();
    check("s3_drained", 16'(bus.out_valid), 16'd0);

    // 4. Steady push+pop at count 2 across pointer wrap
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(8'h10 + i), 8'(i + 1), 3'(i));
      cycle();
    end
    check("s4_setup_count", 16'(count),         16'd2);
    check("s4_setup_valid", 16'(bus.out_valid), 16'd1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'(i * 7 + 1), 8'(i + 3), 3'(i));
      check("s4_count", 16'(count), 16'd2);
      cycle();
    end
    drive(1'b0, '0, '0, '0);
    for (int i = 0; i < 10 && (bus.out_valid || count != 0); i++) cycle();
    check("s4_sb_empty", 16'(exp_q.size()), 16'd0);
    check("s4_received", 16'(received),     16'd13);

    // 5. Reset between edges with three queued plus one held
    bus.out_ready = 1'b0;
    drive(1'b1, 8'h01, 8'h01, 3'd0); step();
    drive(1'b1, 8'h02, 8'h02, 3'd0); step();
    drive(1'b1, 8'h03, 8'h03, 3'd0); step();
    drive(1'b1, 8'h04, 8'h04, 3'd0); step();
    drive(1'b0, '0, '0, '0);
    check("s5_pre_count", 16'(count),         16'd3);
    check("s5_pre_valid", 16'(bus.out_valid), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    check("s5_rst_valid", 16'(bus.out_valid), 16'd0);
    check("s5_rst_en",    16'(alu_en),        16'd0);
    check("s5_rst_count", 16'(count),         16'd0);
    check("s5_rst_q",     16'(bus.out_q),     16'd0);
    #1 rst_n = 1'b1;
    step();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("s5_no_stale", 16'(bus.out_valid), 16'd0);
    end
    drive(1'b1, 8'h80, 8'h80, 3'd0); step();
    drive(1'b0, '0, '0, '0);
    #1;
    check("s5_alu_en", 16'(alu_en), 16'd1);
    check("s5_count",  16'(count),  16'd1);
    step();
    check("s5_valid", 16'(bus.out_valid), 16'd1);
    check("s5_q",     16'(bus.out_q),     16'h100);
    check("s5_zero",  16'(bus.out_zero),  16'd1);
    check("s5_dz",    16'(bus.out_dz),    16'd0);
    step();
    check("s5_drained", 16'(bus.out_valid), 16'd0);

    // 6. Random stream of 1000 commands
    exp_q.delete();
    pushed   = 0;
    received = 0;
    for (int cyc = 0; cyc < 20000 && pushed < 1000; cyc++) begin
      if ($urandom_range(0, 3) != 0)
        drive(1'b1, 8'($urandom), ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
              3'($urandom_range(0, 7)));
      else
        drive(1'b0, '0, '0, '0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drive(1'b0, '0, '0, '0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 50 && (exp_q.size() != 0 || bus.out_valid); i++) cycle();
    check("s6_pushed",   16'(pushed),       16'd1000);
    check("s6_received", 16'(received),     16'd1000);
    check("s6_sb_empty", 16'(exp_q.size()), 16'd0);
    check("s6_count",    16'(count),        16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_cmd_queue.md
Name: alu_cmd_queue

Overview:
- Upstream command buffer and downstream result register for the combinational ALU, in one block.
- Accepts operand/opcode commands over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Issues one command per cycle to the ALU and registers the ALU's Q output with status flags.
- Returns results over a valid/ready handshake, so a purely combinational ALU can sit in a clocked, back-pressured datapath.

Parameters:
- n, 8: operand width; must match the ALU's n.
- DEPTH, 4: command FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- in_valid  in  1  command present.
- in_ready  out  1  FIFO can accept a command.
- in_a  in  n  operand A.
- in_b  in  n  operand B.
- in_sel  in  3  ALU opcode: 000 add, 001 sub, 010 mul, 011 div, 100 and, 101 or, 110 xor, 111 nor.
- alu_a  out  n  to ALU A.
- alu_b  out  n  to ALU B.
- alu_sel  out  3  to ALU sel.
- alu_en  out  1  to ALU en; high only in an issue cycle.
- alu_q  in  n+1  from ALU Q (combinational, same cycle).
- out_valid  out  1  result register holds a result.
- out_ready  in  1  consumer accepts the result.
- out_q  out  n+1  registered result.
- out_zero  out  1  out_q[n-1:0] == 0.
- out_dz  out  1  divide-by-zero: opcode 011 with B == 0.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO emptied: read/write pointers and count = 0.
  - out_valid = 0; out_q, out_zero and out_dz = 0.
  - alu_en = 0; alu_a, alu_b and alu_sel = 0.
  - A reset mid-operation discards all queued commands and any held result. No partial output.
- Push:
  - in_ready = (count < DEPTH). It is combinational from count only.
  - There is no pass-through when full: in_ready stays low at count == DEPTH even if a pop occurs in the same cycle.
  - A push happens on an edge where in_valid && in_ready; {in_a, in_b, in_sel} is written at the write pointer.
- Issue (combinational):
  - issue = (count > 0) && (!out_valid || out_ready).
  - alu_a, alu_b and alu_sel always show the FIFO head when count > 0, and 0 when empty.
  - alu_en = issue.
- Capture: on an edge with issue:
  - out_q <= alu_q.
  - out_zero <= (alu_q[n-1:0] == 0).
  - out_dz <= (head sel == 011 && head b == 0).
  - out_valid <= 1; the FIFO head is popped.
- Drain: on an edge with out_valid && out_ready && !issue, out_valid <= 0.
- Hold: while out_valid && !out_ready, out_q, out_zero and out_dz are held stable and no issue occurs.
- Result value: out_q takes whatever the ALU returns, including its value on divide-by-zero. out_dz is the only error indication.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Latency:
  - A command pushed at edge k is at the head after edge k only if the FIFO was empty.
  - Its result is captured at edge k+1, so out_valid is high in the cycle after edge k+1.
- Throughput: 1 result per cycle with out_ready held high.
- Ordering: results leave strictly in command order. No drop, no duplication.
- Push and pop on an empty FIFO in the same edge: impossible by design, since issue requires count > 0.

Test Plan:
1. Single add, n=8: push A=0x0F, B=0x01, sel=000, out_ready=1 -> alu_en high one cycle; next cycle out_valid=1, out_q=0x010, out_zero=0, out_dz=0; then out_valid=0.
2. Back-pressure, DEPTH=4: out_ready=0, push 5 commands back-to-back -> 1 captured in the output register, count reaches 4, in_ready=0 on the 6th cycle; raise out_ready -> 5 results in push order, one per cycle, count returns to 0.
3. Divide-by-zero and zero flag: push A=0x12, B=0x00, sel=011, then A=0x33, B=0x33, sel=110 -> first result out_dz=1; second out_q[7:0]=0x00, out_zero=1, out_dz=0.
4. Simultaneous push and pop at count=2 with out_valid=1 and out_ready=1 -> count stays 2, exactly one result consumed, pointer wrap verified over 10 such cycles.
5. Reset mid-operation: 3 queued commands plus a held result, assert rst_n low between edges -> out_valid, alu_en and count go to 0 immediately; after release, no stale result appears and the next push behaves as in scenario 1.
6. Random stream, 1000 commands, random in_valid/out_ready -> scoreboard matches every out_q against the ALU model, and no ordering loss.
